// File: rtl/shift_frame_packer_if.sv
// Sample-in / frame-out bundle for shift_frame_packer; slave is the packer side,
// master is the side that feeds samples and consumes frames.
interface shift_frame_packer_if #(
  parameter int WIDTH    = 1,
  parameter int LENGTH   = 8,
  parameter int CHANNELS = 1
);
  localparam int COUNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  logic                               i_en;
  logic [CHANNELS*WIDTH-1:0]          i_data;
  logic                               i_sync;
  logic [CHANNELS*WIDTH-1:0]          o_ser;
  logic [CHANNELS*LENGTH*WIDTH-1:0]   o_par;
  logic [CHANNELS*LENGTH*WIDTH-1:0]   o_word;
  logic                               o_valid;
  logic                               i_ready;
  logic [COUNT_W-1:0]                 o_count;
  logic                               o_overflow;
  logic                               i_clr_ovf;

  modport slave (
    input  i_en, i_data, i_sync, i_ready, i_clr_ovf,
    output o_ser, o_par, o_word, o_valid, o_count, o_overflow
  );

  modport master (
    output i_en, i_data, i_sync, i_ready, i_clr_ovf,
    input  o_ser, o_par, o_word, o_valid, o_count, o_overflow
  );
endinterface

// File: rtl/shift_frame_packer.sv
// Multi-channel serial-to-parallel shifter that captures every LENGTH-th strobe
// into a held frame offered over valid/ready, with sticky overflow detection.
module shift_frame_packer #(
  parameter int WIDTH      = 1,
  parameter int LENGTH     = 8,
  parameter int CHANNELS   = 1,
  parameter int NEWEST_LSB = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  shift_frame_packer_if.slave  bus
);
  localparam int SW      = LENGTH * WIDTH;
  localparam int TW      = CHANNELS * SW;
  localparam int COUNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(LENGTH - 1);

  logic [TW-1:0]             sreg_r;
  logic [TW-1:0]             word_r;
  logic [COUNT_W-1:0]        count_r;
  logic                      valid_r;
  logic                      ovf_r;

  logic [TW-1:0]             shifted_s;
  logic [CHANNELS*WIDTH-1:0] ser_s;
  logic [COUNT_W-1:0]        count_nxt_s;
  logic                      complete_s;
  logic                      transfer_s;
  logic                      valid_nxt_s;
  logic                      ovf_nxt_s;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    if (NEWEST_LSB != 0) begin : g_lsb
      assign shifted_s[c*SW +: SW]   = {sreg_r[c*SW +: SW-WIDTH], bus.i_data[c*WIDTH +: WIDTH]};
      assign ser_s[c*WIDTH +: WIDTH] = sreg_r[c*SW+SW-WIDTH +: WIDTH];
    end else begin : g_msb
      assign shifted_s[c*SW +: SW]   = {bus.i_data[c*WIDTH +: WIDTH], sreg_r[c*SW+WIDTH +: SW-WIDTH]};
      assign ser_s[c*WIDTH +: WIDTH] = sreg_r[c*SW +: WIDTH];
    end
  end

  // Sync suppresses completion even when it coincides with the last strobe.
  assign complete_s = bus.i_en && !bus.i_sync && (count_r == LAST);
  assign transfer_s = valid_r && bus.i_ready;

  // Next-state for counter, valid and overflow flag.
  always_comb begin
    count_nxt_s = count_r;
    valid_nxt_s = valid_r;
    ovf_nxt_s   = ovf_r;

    if (bus.i_sync) begin
      count_nxt_s = '0;
    end else if (bus.i_en) begin
      if (count_r == LAST) begin
        count_nxt_s = '0;
      end else begin
        count_nxt_s = count_r + COUNT_W'(1);
      end
    end else begin
      count_nxt_s = count_r;
    end

    if (complete_s) begin
      valid_nxt_s = 1'b1;
    end else if (transfer_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end

    if (complete_s && valid_r && !bus.i_ready) begin
      ovf_nxt_s = 1'b1;
    end else if (bus.i_clr_ovf) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // State registers; the held frame takes the post-shift value on completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sreg_r  <= '0;
      word_r  <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (bus.i_en) begin
        sreg_r <= shifted_s;
      end
      if (complete_s) begin
        word_r <= shifted_s;
      end
      count_r <= count_nxt_s;
      valid_r <= valid_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign bus.o_par      = sreg_r;
  assign bus.o_ser      = ser_s;
  assign bus.o_word     = word_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_count    = count_r;
  assign bus.o_overflow = ovf_r;
endmodule

// File: tb/tb_shift_frame_packer.sv
// Drives two packer configurations with shared control and checks both against
// a sample-history reference model plus directed frame expectations.
module tb_shift_frame_packer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  shift_frame_packer_if #(.WIDTH(1), .LENGTH(8), .CHANNELS(1)) bus_a ();
  shift_frame_packer_if #(.WIDTH(2), .LENGTH(4), .CHANNELS(2)) bus_b ();

  shift_frame_packer #(.WIDTH(1), .LENGTH(8), .CHANNELS(1), .NEWEST_LSB(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a.slave)
  );
  shift_frame_packer #(.WIDTH(2), .LENGTH(4), .CHANNELS(2), .NEWEST_LSB(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-configuration sample history and handshake flags.
  logic [15:0] hist_a[$];
  logic [15:0] hist_b[$];
  int          m_count[2];
  bit          m_valid[2];
  bit          m_ovf[2];
  logic [63:0] m_word[2];

  function automatic int p_w(input int sel);  return (sel == 0) ? 1 : 2; endfunction
  function automatic int p_l(input int sel);  return (sel == 0) ? 8 : 4; endfunction
  function automatic int p_ch(input int sel); return (sel == 0) ? 1 : 2; endfunction
  function automatic bit p_lsb(input int sel); return (sel == 0); endfunction

  function automatic logic [15:0] sample_at(input int sel, input int age);
    logic [15:0] v;
    v = 16'd0;
    if (sel == 0) begin
      if (age < hist_a.size()) v = hist_a[hist_a.size() - 1 - age];
    end else begin
      if (age < hist_b.size()) v = hist_b[hist_b.size() - 1 - age];
    end
    return v;
  endfunction

  function automatic logic [63:0] frame_of(input int sel);
    logic [63:0] r;
    logic [63:0] s;
    int w, l, pos;
    w = p_w(sel);
    l = p_l(sel);
    r = 64'd0;
    for (int c = 0; c < p_ch(sel); c++) begin
      for (int k = 0; k < l; k++) begin
        s   = 64'(sample_at(sel, k) >> (c * w)) & ((64'd1 << w) - 64'd1);
        pos = p_lsb(sel) ? k : (l - 1 - k);
        r   = r | (s << (c * l * w + pos * w));
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] ser_of(input int sel);
    logic [63:0] r;
    logic [63:0] s;
    int w;
    w = p_w(sel);
    r = 64'd0;
    for (int c = 0; c < p_ch(sel); c++) begin
      s = 64'(sample_at(sel, p_l(sel) - 1) >> (c * w)) & ((64'd1 << w) - 64'd1);
      r = r | (s << (c * w));
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int sel, input bit en, input logic [15:0] smp,
                              input bit sync, input bit ready, input bit clr, input bit rs);
    bit complete, trans, set_ovf;
    int l;
    l = p_l(sel);
    if (rs) begin
      if (sel == 0) hist_a.delete(); else hist_b.delete();
      m_count[sel] = 0;
      m_valid[sel] = 1'b0;
      m_ovf[sel]   = 1'b0;
      m_word[sel]  = 64'd0;
    end else begin
      if (en) begin
        if (sel == 0) begin
          hist_a.push_back(smp);
          while (hist_a.size() > l) void'(hist_a.pop_front());
        end else begin
          hist_b.push_back(smp);
          while (hist_b.size() > l) void'(hist_b.pop_front());
        end
      end
      complete = en && !sync && (m_count[sel] == l - 1);
      trans    = m_valid[sel] && ready;
      set_ovf  = complete && m_valid[sel] && !ready;
      if (sync)    m_count[sel] = 0;
      else if (en) m_count[sel] = (m_count[sel] + 1) % l;
      if (set_ovf)  m_ovf[sel] = 1'b1;
      else if (clr) m_ovf[sel] = 1'b0;
      if (complete) begin
        m_word[sel]  = frame_of(sel);
        m_valid[sel] = 1'b1;
      end else if (trans) begin
        m_valid[sel] = 1'b0;
      end
    end
  endtask

  // One clock: drive both DUTs, advance the model, check every output.
  // bit 4 of data feeds configuration A, bits 3:0 feed configuration B.
  task automatic step(input bit en, input logic [15:0] data, input bit sync,
                      input bit ready, input bit clr, input bit rs);
    rst = rs;
    bus_a.i_en = en; bus_a.i_data = data[4]; bus_a.i_sync = sync;
    bus_a.i_ready = ready; bus_a.i_clr_ovf = clr;
    bus_b.i_en = en; bus_b.i_data = data[3:0]; bus_b.i_sync = sync;
    bus_b.i_ready = ready; bus_b.i_clr_ovf = clr;
    @(posedge clk);
    model_update(0, en, {15'd0, data[4]}, sync, ready, clr, rs);
    model_update(1, en, {12'd0, data[3:0]}, sync, ready, clr, rs);
    #1;
    check_val("a_par",   bus_a.o_par,      frame_of(0));
    check_val("a_ser",   bus_a.o_ser,      ser_of(0));
    check_val("a_word",  bus_a.o_word,     m_word[0]);
    check_val("a_valid", bus_a.o_valid,    64'(m_valid[0]));
    check_val("a_count", bus_a.o_count,    64'(m_count[0]));
    check_val("a_ovf",   bus_a.o_overflow, 64'(m_ovf[0]));
    check_val("b_par",   bus_b.o_par,      frame_of(1));
    check_val("b_ser",   bus_b.o_ser,      ser_of(1));
    check_val("b_word",  bus_b.o_word,     m_word[1]);
    check_val("b_valid", bus_b.o_valid,    64'(m_valid[1]));
    check_val("b_count", bus_b.o_count,    64'(m_count[1]));
    check_val("b_ovf",   bus_b.o_overflow, 64'(m_ovf[1]));
  endtask

  initial begin
    logic [7:0]  bits;
    logic [3:0]  bvals [4];
    logic [7:0]  acc;
    logic [15:0] d;
    bit          b;
    total = 0;
    bad   = 0;
    bits  = 8'b10110010;
    bvals[0] = 4'hC; bvals[1] = 4'h9; bvals[2] = 4'h6; bvals[3] = 4'h3;

    step(1'b1, 16'h001F, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("rst_count", bus_a.o_count, 64'd0);
    check_val("rst_par",   bus_a.o_par,   64'd0);

    // Basic shift, and the direction/channel pattern on B.
    for (int i = 0; i < 8; i++) begin
      d = {11'd0, bits[7 - i], (i < 4) ? bvals[i] : 4'h0};
      step(1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 3) check_val("dir_word", bus_b.o_word, 64'h1BE4);
    end
    check_val("shift_word",  bus_a.o_word,  64'hB2);
    check_val("shift_valid", bus_a.o_valid, 64'd1);
    check_val("shift_ser",   bus_a.o_ser,   64'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("shift_drop",  bus_a.o_valid, 64'd0);

    // Backpressure across two frames.
    acc = 8'd0;
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom_range(0, 31));
      acc = {acc[6:0], d[4]};
      step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_val("bp_valid", bus_a.o_valid,    64'd1);
    check_val("bp_ovf",   bus_a.o_overflow, 64'd1);
    check_val("bp_word",  bus_a.o_word,     64'(acc));
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("clr_ovf",  bus_a.o_overflow, 64'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("bp_drain", bus_a.o_valid,    64'd0);

    // Completion coinciding with acceptance.
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom_range(0, 31));
      acc = {acc[6:0], d[4]};
      step(1'b1, d, 1'b0, (i == 15), 1'b0, 1'b0);
    end
    check_val("sim_valid", bus_a.o_valid,    64'd1);
    check_val("sim_word",  bus_a.o_word,     64'(acc));
    check_val("sim_ovf",   bus_a.o_overflow, 64'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

    // Sync mid-frame.
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom_range(0, 31)), 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("sync_pre", bus_a.o_count, 64'd3);
    step(1'b1, 16'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("sync_count", bus_a.o_count, 64'd0);
    check_val("sync_valid", bus_a.o_valid, 64'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 16'($urandom_range(0, 31)), 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("sync_7", bus_a.o_valid, 64'd0);
    step(1'b1, 16'($urandom_range(0, 31)), 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("sync_8", bus_a.o_valid, 64'd1);

    // Random gapped traffic.
    for (int i = 0; i < 400; i++) begin
      b = ($urandom_range(0, 127) == 0);
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), b);
    end

    // Reset mid-frame while a frame is pending.
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) step(1'b1, 16'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("pre_rst_count", bus_a.o_count, 64'd5);
    check_val("pre_rst_valid", bus_a.o_valid, 64'd1);
    step(1'b1, 16'h001F, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("rst_all", {bus_a.o_par, bus_a.o_word, 3'(bus_a.o_count), bus_a.o_valid,
                          bus_a.o_overflow, bus_a.o_ser}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
